sweep_acq_controller: RTL and testbench

Sequencer that drives the DAC-sweep acquisition path of the mode switcher when it is in sweep-acquisition mode (ModeSelect = 2'b10). It steps one 10-bit Microroc threshold DAC from a start to an end code. At each point it reloads slow-control parameters, runs a Microroc acquisition, and forwards a fixed number of acquired words toward the USB FIFO. It produces the SweepAcq* signals the switcher selects and consumes the ParallelData stream the switcher routes back.

---
 rtl/sweep_acq_controller.sv | 197 +++++++++++++++++++
 tb/tb_sweep_acq_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_acq_controller.sv
// sweep_acq_controller
//   Steps a 10-bit Microroc threshold DAC from StartDac to EndDac by DacStep.
//   At each point it pulses an SC parameter load, waits, and optionally emits
//   a two-word header (HEADER_TAG, {6'b0, dac}). It then runs an acquisition
//   that forwards MaxWordCount ParallelData words, and finishes the point
//   with a force-reset pulse.
//   Optional feature macro: SWEEP_ACQ_HEADER_EN (header words per point).
// Ports:
//   Clk, reset (sync, active high)
//   SweepStart                       level start/stop, rising edge starts
//   StartDac/EndDac/DacStep          sweep range, latched at start
//   MaxWordCount                     words forwarded per DAC point
//   ParallelData/_en                 acquisition stream in
//   SweepAcq10BitDac                 current DAC code
//   SweepAcqMicrorocSCParameterLoad  1-cycle SC load pulse
//   SweepAcqMicrorocAcqStartStop     high while acquiring
//   SweepAcqForceMicrorocAcqReset    RESET_CYCLES-wide reset pulse
//   SweepAcqData/_en                 forwarded stream out (1-cycle latency)
//   SweepAcqDone                     held until SweepStart drops
module sweep_acq_controller #(
  parameter int unsigned LOAD_WAIT_CYCLES = 100,
  parameter int unsigned RESET_CYCLES     = 8,
  parameter logic [15:0] HEADER_TAG       = 16'hFFD0
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        SweepStart,
  input  logic [9:0]  StartDac,
  input  logic [9:0]  EndDac,
  input  logic [9:0]  DacStep,
  input  logic [15:0] MaxWordCount,
  input  logic [15:0] ParallelData,
  input  logic        ParallelData_en,
  output logic [9:0]  SweepAcq10BitDac,
  output logic        SweepAcqMicrorocSCParameterLoad,
  output logic        SweepAcqMicrorocAcqStartStop,
  output logic        SweepAcqForceMicrorocAcqReset,
  output logic [15:0] SweepAcqData,
  output logic        SweepAcqData_en,
  output logic        SweepAcqDone
);

  typedef enum logic [3:0] {
    IDLE, SET_DAC, LOAD, LOAD_WAIT, HDR0, HDR1, ACQ, STOP, NEXT, DONE
  } state_t;

  localparam logic [15:0] LW_LAST  = 16'(LOAD_WAIT_CYCLES - 1);
  localparam logic [7:0]  RST_LAST = 8'(RESET_CYCLES - 1);

  state_t      state, state_n;
  logic        prev;
  logic [9:0]  dac, dac_n, end_l, end_n, step_l, step_n;
  logic [15:0] max_l, max_n, wcnt, wcnt_n, wait_cnt, wait_n;
  logic [7:0]  rst_cnt, rst_n;
  logic        abort_q, abort_n;
  logic [15:0] data_q, data_n;
  logic        data_en_q, data_en_n;
  logic        load_q, acq_q, frst_q, done_q;
  logic [10:0] nxt;
  state_t      acq_tgt;
  logic        abort_now;

  always_comb begin
    state_n   = state;
    dac_n     = dac;
    end_n     = end_l;
    step_n    = step_l;
    max_n     = max_l;
    wcnt_n    = wcnt;
    wait_n    = '0;      // counters idle at zero outside their own state
    rst_n     = '0;
    abort_n   = abort_q;
    data_n    = data_q;
    data_en_n = 1'b0;
    nxt       = {1'b0, dac} + {1'b0, step_l};
    // a zero word count skips the acquisition entirely
    acq_tgt   = (max_l == 16'd0) ? STOP : ACQ;
    abort_now = !SweepStart && (state != IDLE) && (state != DONE) && (state != STOP);

    if (abort_now) begin
      // abort wins over everything, including a word-count hit in ACQ
      state_n = STOP;
      abort_n = 1'b1;
    end else begin
      case (state)
        IDLE: if (SweepStart && !prev) begin
          dac_n   = StartDac;
          end_n   = EndDac;
          step_n  = DacStep;
          max_n   = MaxWordCount;
          wcnt_n  = '0;
          abort_n = 1'b0;
          state_n = SET_DAC;
        end
        SET_DAC: state_n = LOAD;
        LOAD:    state_n = LOAD_WAIT;
        LOAD_WAIT: begin
          if (wait_cnt == LW_LAST) begin
`ifdef SWEEP_ACQ_HEADER_EN
            state_n = HDR0;
`else
            state_n = acq_tgt;
`endif
          end else begin
            wait_n = wait_cnt + 16'd1;
          end
        end
`ifdef SWEEP_ACQ_HEADER_EN
        HDR0: state_n = HDR1;
        HDR1: state_n = acq_tgt;
`endif
        ACQ: if (ParallelData_en) begin
          data_n    = ParallelData;
          data_en_n = 1'b1;
          wcnt_n    = wcnt + 16'd1;
          if (wcnt + 16'd1 == max_l) state_n = STOP;
        end
        STOP: begin
          if (!SweepStart) abort_n = 1'b1;
          if (rst_cnt == RST_LAST)
            state_n = (abort_q || !SweepStart) ? IDLE : NEXT;
          else
            rst_n = rst_cnt + 8'd1;
        end
        NEXT: begin
          // 11-bit sum catches wrap past 1023 as well as passing EndDac
          if (step_l == 10'd0 || nxt > {1'b0, end_l} || nxt[10]) begin
            state_n = DONE;
          end else begin
            dac_n   = nxt[9:0];
            wcnt_n  = '0;
            state_n = SET_DAC;
          end
        end
        DONE:    if (!SweepStart) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end

`ifdef SWEEP_ACQ_HEADER_EN
    if (state_n == HDR0) begin
      data_n    = HEADER_TAG;
      data_en_n = 1'b1;
    end else if (state_n == HDR1) begin
      data_n    = {6'b0, dac};
      data_en_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state     <= IDLE;
      prev      <= 1'b1;  // a level still high after reset must not look like an edge
      dac       <= '0;
      end_l     <= '0;
      step_l    <= '0;
      max_l     <= '0;
      wcnt      <= '0;
      wait_cnt  <= '0;
      rst_cnt   <= '0;
      abort_q   <= 1'b0;
      data_q    <= '0;
      data_en_q <= 1'b0;
      load_q    <= 1'b0;
      acq_q     <= 1'b0;
      frst_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      prev      <= SweepStart;
      dac       <= dac_n;
      end_l     <= end_n;
      step_l    <= step_n;
      max_l     <= max_n;
      wcnt      <= wcnt_n;
      wait_cnt  <= wait_n;
      rst_cnt   <= rst_n;
      abort_q   <= abort_n;
      data_q    <= data_n;
      data_en_q <= data_en_n;
      load_q    <= (state_n == LOAD);
      acq_q     <= (state_n == ACQ);
      frst_q    <= (state_n == STOP);
      done_q    <= (state_n == DONE);
    end
  end

  assign SweepAcq10BitDac                = dac;
  assign SweepAcqMicrorocSCParameterLoad = load_q;
  assign SweepAcqMicrorocAcqStartStop    = acq_q;
  assign SweepAcqForceMicrorocAcqReset   = frst_q;
  assign SweepAcqData                    = data_q;
  assign SweepAcqData_en                 = data_en_q;
  assign SweepAcqDone                    = done_q;

endmodule

// File: tb/tb_sweep_acq_controller.sv
module tb_sweep_acq_controller;

  logic        Clk = 1'b0;
  logic        reset = 1'b1;
  logic        SweepStart = 1'b0;
  logic [9:0]  StartDac = '0, EndDac = '0, DacStep = '0;
  logic [15:0] MaxWordCount = '0, ParallelData = '0;
  logic        ParallelData_en = 1'b0;
  logic [9:0]  dac;
  logic        load, acq, frst, data_en, done;
  logic [15:0] data;

  sweep_acq_controller #(.LOAD_WAIT_CYCLES(10), .RESET_CYCLES(8), .HEADER_TAG(16'hFFD0)) dut (
    .Clk(Clk), .reset(reset), .SweepStart(SweepStart),
    .StartDac(StartDac), .EndDac(EndDac), .DacStep(DacStep), .MaxWordCount(MaxWordCount),
    .ParallelData(ParallelData), .ParallelData_en(ParallelData_en),
    .SweepAcq10BitDac(dac), .SweepAcqMicrorocSCParameterLoad(load),
    .SweepAcqMicrorocAcqStartStop(acq), .SweepAcqForceMicrorocAcqReset(frst),
    .SweepAcqData(data), .SweepAcqData_en(data_en), .SweepAcqDone(done));

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0, load_cnt = 0;
  logic acq_seen = 1'b0;
  logic [15:0] data_q[$];
  logic [9:0]  load_dac_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: pop expectations as the DUT produces output
  always @(negedge Clk) begin
    if (!reset) begin
      if (acq) acq_seen = 1'b1;
      if (data_en) begin
        if (data_q.size() == 0) check("data_unexpected", data, 32'hDEAD_BEEF);
        else check("data_word", data, data_q.pop_front());
      end
      if (load) begin
        load_cnt++;
        if (load_dac_q.size() == 0) check("load_unexpected", dac, 32'hDEAD_BEEF);
        else check("load_dac", dac, load_dac_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic push_hdr(input logic [9:0] d);
`ifdef SWEEP_ACQ_HEADER_EN
    data_q.push_back(16'hFFD0);
    data_q.push_back({6'b0, d});
`else
    if (d == 10'h3FF) data_q.delete(); // no header in this build
`endif
  endtask

  task automatic wait_acq(input string tag);
    int n = 0;
    while (acq !== 1'b1 && n < 300) begin tick(); n++; end
    check(tag, (n >= 300), 0);
  endtask

  task automatic wait_frst(input string tag);
    int n = 0;
    while (frst !== 1'b1 && n < 300) begin tick(); n++; end
    check(tag, (n >= 300), 0);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 300) begin tick(); n++; end
    check(tag, (n >= 300), 0);
  endtask

  task automatic drive_word();
    logic [15:0] d;
    d = 16'($urandom);
    ParallelData = d;
    ParallelData_en = 1'b1;
    data_q.push_back(d);
    tick();
    ParallelData_en = 1'b0;
  endtask

  // one acquisition of n words with a strobe every 4th cycle
  task automatic run_point(input int n, input string tag);
    wait_acq({tag, "_acq_rise"});
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (3) tick();
      drive_word();
    end
    check({tag, "_acq_fall"}, acq, 0);
    check({tag, "_frst_rise"}, frst, 1);
  endtask

  task automatic set_params(input logic [9:0] s, input logic [9:0] e, input logic [9:0] st,
                            input logic [15:0] m);
    StartDac = s; EndDac = e; DacStep = st; MaxWordCount = m;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    check("rst_dac", dac, 0);
    check("rst_load", load, 0);
    check("rst_acq", acq, 0);
    check("rst_frst", frst, 0);
    check("rst_data", data, 0);
    check("rst_data_en", data_en, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    repeat (2) tick();

    // basic sweep 100..104 step 2, 3 words per point
    set_params(10'd100, 10'd104, 10'd2, 16'd3);
    for (int p = 0; p < 3; p++) load_dac_q.push_back(10'(100 + 2 * p));
    for (int p = 0; p < 3; p++) begin
      push_hdr(10'(100 + 2 * p));
      if (p == 0) begin
        SweepStart = 1'b1;
        tick();
        check("start_lat_load0", load, 0);
        tick();
        check("start_lat_load1", load, 1);
        check("start_lat_dac", dac, 100);
      end
      run_point(3, "basic");
    end
    repeat (7) tick();
    check("basic_frst_last", frst, 1);
    tick();
    check("basic_frst_end", frst, 0);
    check("basic_done_early", done, 0);
    tick();
    check("basic_done", done, 1);
    check("basic_loads", load_cnt, 3);
    // done handshake
    repeat (5) tick();
    check("done_hold", done, 1);
    SweepStart = 1'b0;
    tick();
    check("done_clear", done, 0);
    repeat (2) tick();

    // top of range: 1020 + 5 overflows 10 bits
    set_params(10'd1020, 10'd1023, 10'd5, 16'd1);
    load_dac_q.push_back(10'd1020);
    push_hdr(10'd1020);
    SweepStart = 1'b1;
    run_point(1, "ovf");
    wait_done("ovf_done");
    check("ovf_dac", dac, 1020);
    check("ovf_loads", load_cnt, 4);
    SweepStart = 1'b0;
    repeat (2) tick();

    // zero step: single point
    set_params(10'd5, 10'd50, 10'd0, 16'd2);
    load_dac_q.push_back(10'd5);
    push_hdr(10'd5);
    SweepStart = 1'b1;
    run_point(2, "step0");
    wait_done("step0_done");
    check("step0_loads", load_cnt, 5);
    SweepStart = 1'b0;
    repeat (2) tick();

    // start above end: single point
    set_params(10'd30, 10'd10, 10'd1, 16'd1);
    load_dac_q.push_back(10'd30);
    push_hdr(10'd30);
    SweepStart = 1'b1;
    run_point(1, "rev");
    wait_done("rev_done");
    check("rev_loads", load_cnt, 6);
    SweepStart = 1'b0;
    repeat (2) tick();

    // abort during ACQ after 1 of 4 words
    set_params(10'd200, 10'd210, 10'd1, 16'd4);
    load_dac_q.push_back(10'd200);
    push_hdr(10'd200);
    SweepStart = 1'b1;
    wait_acq("abort_acq_rise");
    drive_word();
    repeat (2) tick();
    SweepStart = 1'b0;
    tick();
    check("abort_acq_fall", acq, 0);
    check("abort_frst", frst, 1);
    n = 1;
    while (n < 50) begin
      tick();
      if (frst === 1'b1) n++; else break;
    end
    check("abort_frst_len", n, 8);
    repeat (5) tick();
    check("abort_done", done, 0);
    check("abort_loads", load_cnt, 7);

    // zero word count, strobes during LOAD_WAIT must be dropped
    set_params(10'd7, 10'd7, 10'd1, 16'd0);
    load_dac_q.push_back(10'd7);
    push_hdr(10'd7);
    acq_seen = 1'b0;
    SweepStart = 1'b1;
    repeat (4) tick();
    ParallelData = 16'h1234;
    ParallelData_en = 1'b1;
    repeat (3) tick();
    ParallelData_en = 1'b0;
    wait_frst("mwc0_frst");
    wait_done("mwc0_done");
    check("mwc0_no_acq", acq_seen, 0);
    check("mwc0_queue", data_q.size(), 0);
    SweepStart = 1'b0;
    repeat (2) tick();

    // reset in LOAD_WAIT with SweepStart held high
    set_params(10'd300, 10'd310, 10'd1, 16'd1);
    load_dac_q.push_back(10'd300);
    SweepStart = 1'b1;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_dac", dac, 0);
    check("mid_rst_frst", frst, 0);
    check("mid_rst_data_en", data_en, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("mid_rst_no_restart_loads", load_cnt, 9);
    check("mid_rst_acq", acq, 0);
    check("mid_rst_dac_idle", dac, 0);
    SweepStart = 1'b0;
    tick();
    set_params(10'd400, 10'd400, 10'd1, 16'd1);
    load_dac_q.push_back(10'd400);
    push_hdr(10'd400);
    SweepStart = 1'b1;
    run_point(1, "relatch");
    wait_done("relatch_done");
    check("relatch_dac", dac, 400);
    SweepStart = 1'b0;
    repeat (3) tick();

    check("final_data_q", data_q.size(), 0);
    check("final_load_q", load_dac_q.size(), 0);
    check("final_loads", load_cnt, 10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
